// File: rtl/ibex_hpm_unit_pkg.sv
// Shared CSR numbering and sizing constants for the hardware performance monitor.
package ibex_hpm_unit_pkg;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT  = 12'h320,
    CSR_MHPMEVENT3     = 12'h323,
    CSR_MHPMEVENT31    = 12'h33F,
    CSR_MHPMOVF        = 12'h7C0,
    CSR_MHPMCOUNTER3   = 12'hB03,
    CSR_MHPMCOUNTER31  = 12'hB1F,
    CSR_MHPMCOUNTER3H  = 12'hB83,
    CSR_MHPMCOUNTER31H = 12'hB9F
  } csr_num_e;

  localparam int unsigned HPM_MAX_COUNTERS = 29;
  localparam int unsigned HPM_FIRST_IDX    = 3;
  localparam int unsigned HPM_MAX_WIDTH    = 64;

  // True when addr lies in the inclusive window [lo, hi].
  function automatic logic in_window(logic [11:0] addr, csr_num_e lo, csr_num_e hi);
    return (addr >= 12'(lo)) && (addr <= 12'(hi));
  endfunction

endpackage

// File: rtl/ibex_hpm_counter.sv
// One performance counter: value register, +1 increment, wrap and sticky overflow flag.
module ibex_hpm_counter
  import ibex_hpm_unit_pkg::*;
#(
  parameter int unsigned CounterWidth = 40
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_inc,
  input  logic                    i_we_lo,
  input  logic                    i_we_hi,
  input  logic [31:0]             i_wdata,
  input  logic                    i_ovf_clr,
  output logic [CounterWidth-1:0] o_cnt,
  output logic                    o_ovf
);

  logic [CounterWidth-1:0]  r_cnt;
  logic                     r_ovf;
  logic [HPM_MAX_WIDTH-1:0] w_full;
  logic                     w_wr;
  logic                     w_wrap;
  logic                     unused_full;

  // Merge a half-word CSR write into the current value, widened to the max width.
  always_comb begin
    w_full = HPM_MAX_WIDTH'(r_cnt);
    if (i_we_lo) w_full[31:0]  = i_wdata;
    if (i_we_hi) w_full[63:32] = i_wdata;
  end

  // A CSR write always beats a same-cycle increment, so it also suppresses the wrap.
  assign w_wr        = i_we_lo | i_we_hi;
  assign w_wrap      = i_inc & ~w_wr & (&r_cnt);
  assign unused_full = ^w_full;

  // Counter value: write, else increment (natural wrap to zero from all-ones).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_cnt <= '0;
    else if (w_wr)  r_cnt <= w_full[CounterWidth-1:0];
    else if (i_inc) r_cnt <= r_cnt + CounterWidth'(1);
  end

  // Sticky overflow flag; a wrap in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ovf <= 1'b0;
    else         r_ovf <= w_wrap | (r_ovf & ~i_ovf_clr);
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/ibex_hpm_unit.sv
// HPM CSR block: event masks, inhibit bits, counters, overflow flags and CSR read mux.
module ibex_hpm_unit
  import ibex_hpm_unit_pkg::*;
#(
  parameter int unsigned NumCounters  = 10,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic [NumEvents-1:0] event_i,
  input  logic                 count_stop_i,
  output logic                 ovf_irq_o
);

  logic                                  w_sel_evt;
  logic                                  w_sel_lo;
  logic                                  w_sel_hi;
  logic                                  w_sel_inh;
  logic                                  w_sel_ovf;
  logic [4:0]                            w_idx;
  logic [HPM_MAX_COUNTERS-1:0][31:0]     w_evt_arr;
  logic [HPM_MAX_COUNTERS-1:0][63:0]     w_cnt_arr;
  logic [HPM_MAX_COUNTERS-1:0]           w_inh_arr;
  logic [HPM_MAX_COUNTERS-1:0]           w_ovf_arr;

  // Address decode; the low five address bits give the counter number 3..31.
  assign w_sel_evt = in_window(csr_addr_i, CSR_MHPMEVENT3, CSR_MHPMEVENT31);
  assign w_sel_lo  = in_window(csr_addr_i, CSR_MHPMCOUNTER3, CSR_MHPMCOUNTER31);
  assign w_sel_hi  = in_window(csr_addr_i, CSR_MHPMCOUNTER3H, CSR_MHPMCOUNTER31H);
  assign w_sel_inh = (csr_addr_i == 12'(CSR_MCOUNTINHIBIT));
  assign w_sel_ovf = (csr_addr_i == 12'(CSR_MHPMOVF));
  assign w_idx     = csr_addr_i[4:0] - 5'(HPM_FIRST_IDX);

  for (genvar i = 0; i < HPM_MAX_COUNTERS; i++) begin : g_ctr
    if (i < NumCounters) begin : g_impl
      logic [NumEvents-1:0]    r_evt;
      logic                    r_inh;
      logic                    w_hit_me;
      logic                    w_inc;
      logic [CounterWidth-1:0] w_cnt;
      logic                    w_ovf;

      assign w_hit_me = csr_we_i & (w_idx == 5'(i));
      // Any matching event counts once, regardless of how many bits match.
      assign w_inc    = (|(event_i & r_evt)) & ~r_inh & ~count_stop_i;

      // Event selector mask.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   r_evt <= '0;
        else if (w_hit_me & w_sel_evt) r_evt <= csr_wdata_i[NumEvents-1:0];
      end

      // Inhibit bit; resets set so nothing counts until software enables it.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 r_inh <= 1'b1;
        else if (csr_we_i & w_sel_inh) r_inh <= csr_wdata_i[HPM_FIRST_IDX+i];
      end

      ibex_hpm_counter #(
        .CounterWidth(CounterWidth)
      ) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_inc    (w_inc),
        .i_we_lo  (w_hit_me & w_sel_lo),
        .i_we_hi  (w_hit_me & w_sel_hi),
        .i_wdata  (csr_wdata_i),
        .i_ovf_clr(csr_we_i & w_sel_ovf & csr_wdata_i[HPM_FIRST_IDX+i]),
        .o_cnt    (w_cnt),
        .o_ovf    (w_ovf)
      );

      assign w_evt_arr[i] = 32'(r_evt);
      assign w_cnt_arr[i] = 64'(w_cnt);
      assign w_inh_arr[i] = r_inh;
      assign w_ovf_arr[i] = w_ovf;
    end else begin : g_none
      assign w_evt_arr[i] = '0;
      assign w_cnt_arr[i] = '0;
      assign w_inh_arr[i] = 1'b0;
      assign w_ovf_arr[i] = 1'b0;
    end
  end

  // Zero-latency read mux; unimplemented slots read zero but still hit.
  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = 1'b0;
    if (w_sel_evt) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = w_evt_arr[w_idx];
    end else if (w_sel_lo) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = w_cnt_arr[w_idx][31:0];
    end else if (w_sel_hi) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = w_cnt_arr[w_idx][63:32];
    end else if (w_sel_inh) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = {w_inh_arr, 3'b000};
    end else if (w_sel_ovf) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = {w_ovf_arr, 3'b000};
    end
  end

  assign ovf_irq_o = |w_ovf_arr;

endmodule

// File: tb/tb_ibex_hpm_unit.sv
// Randomized self-checking bench for ibex_hpm_unit against a per-cycle arithmetic model.
module tb_ibex_hpm_unit;
  localparam int NC = 10, CW = 40, NE = 16;
  localparam longint unsigned CMASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
  localparam logic [31:0] EMASK = (NE == 32) ? 32'hFFFF_FFFF : ((32'd1 << NE) - 32'd1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [11:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          hit;
  logic [NE-1:0] ev = '0;
  logic          stop = 1'b0;
  logic          irq;

  int n_chk = 0, n_err = 0;

  // Reference state: counter values, masks, inhibit and overflow per implemented counter.
  longint unsigned m_cnt[NC];
  logic [31:0]     m_evt[NC];
  bit              m_inh[NC];
  bit              m_ovf[NC];

  always #5 clk = ~clk;

  ibex_hpm_unit #(.NumCounters(NC), .CounterWidth(CW), .NumEvents(NE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
    .csr_rdata_o(rdata), .csr_hit_o(hit), .event_i(ev), .count_stop_i(stop), .ovf_irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = 0; m_evt[k] = 0; m_inh[k] = 1; m_ovf[k] = 0;
    end
  endfunction

  function automatic bit mdl_owned(input logic [11:0] a);
    return (a >= 12'h323 && a <= 12'h33F) || (a >= 12'hB03 && a <= 12'hB1F) ||
           (a >= 12'hB83 && a <= 12'hB9F) || a == 12'h320 || a == 12'h7C0;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [11:0] a);
    logic [31:0] r;
    int k;
    r = 0;
    if (a >= 12'h323 && a <= 12'h33F) begin
      k = int'(a) - 'h323;
      if (k < NC) r = m_evt[k];
    end else if (a >= 12'hB03 && a <= 12'hB1F) begin
      k = int'(a) - 'hB03;
      if (k < NC) r = 32'(m_cnt[k]);
    end else if (a >= 12'hB83 && a <= 12'hB9F) begin
      k = int'(a) - 'hB83;
      if (k < NC) r = 32'(m_cnt[k] >> 32);
    end else if (a == 12'h320) begin
      for (int j = 0; j < NC; j++) r[3+j] = m_inh[j];
    end else if (a == 12'h7C0) begin
      for (int j = 0; j < NC; j++) r[3+j] = m_ovf[j];
    end
    return r;
  endfunction

  function automatic bit mdl_irq();
    bit any = 0;
    for (int k = 0; k < NC; k++) any |= m_ovf[k];
    return any;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  function automatic void mdl_step();
    bit inc[NC];
    bit set;
    for (int k = 0; k < NC; k++)
      inc[k] = ((32'(ev) & m_evt[k]) != 0) && !m_inh[k] && !stop;
    for (int k = 0; k < NC; k++) begin
      set = 0;
      if (we && addr == 12'h320) m_inh[k] = wdata[3+k];
      if (we && addr == 12'(12'h323 + k)) m_evt[k] = wdata & EMASK;
      if (we && addr == 12'(12'hB03 + k))
        m_cnt[k] = (((m_cnt[k] >> 32) << 32) | 64'(wdata)) & CMASK;
      else if (we && addr == 12'(12'hB83 + k))
        m_cnt[k] = ((m_cnt[k] & 64'hFFFF_FFFF) | (64'(wdata) << 32)) & CMASK;
      else if (inc[k]) begin
        if (m_cnt[k] == CMASK) begin m_cnt[k] = 0; set = 1; end
        else m_cnt[k] = m_cnt[k] + 1;
      end
      m_ovf[k] = set || (m_ovf[k] && !(we && addr == 12'h7C0 && wdata[3+k]));
    end
  endfunction

  task automatic cyc(input bit w, input logic [11:0] a, input logic [31:0] d,
                     input logic [NE-1:0] e, input bit s);
    we = w; addr = a; wdata = d; ev = e; stop = s;
    @(posedge clk);
    mdl_step();
    #1;
    we = 0; ev = '0; stop = 0;
  endtask

  // Read an address and compare data/hit against the model.
  task automatic rd(input string tag, input logic [11:0] a);
    we = 0; addr = a; #1;
    check(tag, rdata, mdl_rd(a));
    check({tag, "_hit"}, 32'(hit), 32'(mdl_owned(a)));
  endtask

  // Read an address and compare data against a fixed expected constant.
  task automatic rdc(input string tag, input logic [11:0] a, input logic [31:0] exp);
    we = 0; addr = a; #1;
    check(tag, rdata, exp);
  endtask

  function automatic logic [11:0] pick();
    case ($urandom_range(7))
      0: return 12'h320;
      1: return 12'h7C0;
      2: return 12'(12'h323 + $urandom_range(12));
      3, 4: return 12'(12'hB03 + $urandom_range(12));
      5: return 12'(12'hB83 + $urandom_range(12));
      6: return 12'hB14;
      default: return 12'(12'h300 + $urandom_range(63));
    endcase
  endfunction

  initial begin
    mdl_reset();
    #12;
    rdc("rst_inh", 12'h320, 32'h0000_1FF8);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 12'h0, 0, NE'($urandom), 0);
    rdc("rst_cnt3", 12'hB03, 0);
    rdc("rst_cnt12", 12'hB0C, 0);
    rdc("rst_ovf", 12'h7C0, 0);

    // Basic counting: two matching bits still add one per cycle.
    cyc(1, 12'h320, 32'h0, '0, 0);
    cyc(1, 12'h323, 32'h3, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 12'h0, 0, NE'(3), 0);
    rdc("cnt3_5", 12'hB03, 32'd5);

    // Wrap of counter 4 from all-ones.
    cyc(1, 12'h324, 32'h1, '0, 0);
    cyc(1, 12'hB84, 32'hFF, '0, 0);
    cyc(1, 12'hB04, 32'hFFFF_FFFF, '0, 0);
    rdc("cnt4h_ff", 12'hB84, 32'hFF);
    cyc(0, 12'h0, 0, NE'(1), 0);
    rdc("wrap_lo", 12'hB04, 32'd0);
    rdc("wrap_hi", 12'hB84, 32'd0);
    rdc("wrap_ovf", 12'h7C0, 32'h10);
    check("wrap_irq", 32'(irq), 32'd1);

    // Write beats a same-cycle increment.
    cyc(1, 12'hB03, 32'h100, NE'(1), 0);
    rdc("wr_prec", 12'hB03, 32'h100);

    // Overflow set wins over a coincident W1C.
    cyc(1, 12'hB83, 32'hFF, '0, 0);
    cyc(1, 12'hB03, 32'hFFFF_FFFF, '0, 0);
    cyc(0, 12'h0, 0, NE'(2), 0);
    rdc("ovf3_set", 12'h7C0, 32'h18);
    cyc(1, 12'hB83, 32'hFF, '0, 0);
    cyc(1, 12'hB03, 32'hFFFF_FFFF, '0, 0);
    cyc(1, 12'h7C0, 32'h8, NE'(2), 0);
    rdc("w1c_race", 12'h7C0, 32'h18);
    cyc(1, 12'h7C0, 32'h18, '0, 0);
    rdc("w1c_clr", 12'h7C0, 32'h0);
    check("w1c_irq", 32'(irq), 32'd0);

    // count_stop freezes everything.
    cyc(1, 12'hB03, 32'h40, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 12'h0, 0, NE'(3), 1);
    rdc("stop3", 12'hB03, 32'h40);
    rd("stop4", 12'hB04);

    // Unimplemented counter 20 and unowned neighbours.
    cyc(1, 12'hB14, 32'h1234, '0, 0);
    rdc("unimpl_rd", 12'hB14, 32'h0);
    check("unimpl_hit", 32'(hit), 32'd1);
    rdc("unowned_rd", 12'h321, 32'h0);
    check("unowned_hit", 32'(hit), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = pick();
      d = $urandom;
      if (a == 12'h320) d = $urandom & $urandom & $urandom;
      else if (a >= 12'hB83 && a <= 12'hB9F) d = ($urandom_range(3) == 0) ? d : 32'hFF;
      else if (a >= 12'hB03 && a <= 12'hB1F) d = d | 32'hFFFF_FF00;
      cyc($urandom_range(2) == 0, a, d, NE'($urandom & $urandom), $urandom_range(7) == 0);
      rd($sformatf("rnd%0d", i), pick());
      check($sformatf("rnd_irq%0d", i), 32'(irq), 32'(mdl_irq()));
    end

    // Make sure something is counting and overflowed, then reset mid-count.
    cyc(1, 12'h320, 32'h0, '0, 0);
    cyc(1, 12'h325, 32'h1, '0, 0);
    cyc(1, 12'hB85, 32'hFF, '0, 0);
    cyc(1, 12'hB05, 32'hFFFF_FFFF, '0, 0);
    cyc(0, 12'h0, 0, NE'(1), 0);
    check("pre_rst_irq", 32'(irq), 32'd1);
    #1 rst_n = 1'b0;
    mdl_reset();
    rdc("mid_inh", 12'h320, 32'h0000_1FF8);
    rdc("mid_cnt5", 12'hB05, 32'h0);
    rdc("mid_ovf", 12'h7C0, 32'h0);
    rdc("mid_evt5", 12'h325, 32'h0);
    check("mid_irq", 32'(irq), 32'd0);
    #1 rst_n = 1'b1;

    // Nothing counts until inhibit is cleared.
    cyc(1, 12'h323, 32'h1, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 12'h0, 0, NE'(1), 0);
    rdc("inh_hold", 12'hB03, 32'h0);
    cyc(1, 12'h320, 32'h0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 12'h0, 0, NE'(1), 0);
    rdc("inh_clr", 12'hB03, 32'h3);
    rd("final_inh", 12'h320);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_hpm_unit.md
IBEX_HPM_UNIT -- requirements
Module: ibex_hpm_unit

Interface
REQ-001 SHALL have parameter NumCounters, default 10, meaning the number of implemented counters mhpmcounter3..(3+NumCounters-1), with a legal range of 0..29.
REQ-002 SHALL have parameter CounterWidth, default 40, meaning the bits per counter, with a legal range of 1..64.
REQ-003 SHALL have parameter NumEvents, default 16, meaning the width of the event bus and of each mhpmevent mask, with a legal range of 1..32.
REQ-004 SHALL use a single clock and an asynchronous, active-low reset.
REQ-005 Port clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 Port rst_ni  input  1  asynchronous active-low reset.
REQ-007 Port csr_we_i  input  1  CSR write strobe.
REQ-008 Port csr_addr_i  input  12  CSR address.
REQ-009 Port csr_wdata_i  input  32  CSR write data, already resolved for set/clear.
REQ-010 Port csr_rdata_o  output  32  read data for csr_addr_i.
REQ-011 Port csr_hit_o  output  1  high when csr_addr_i is an address this block owns.
REQ-012 Port event_i  input  NumEvents  single-cycle event pulses.
REQ-013 Port count_stop_i  input  1  freezes all counting, e.g. in debug mode.
REQ-014 Port ovf_irq_o  output  1  high while any overflow flag is set.

Function
REQ-015 Owned addresses SHALL be:
- MHPMEVENT3..31
- MHPMCOUNTER3..31
- MHPMCOUNTER3H..31H
- MCOUNTINHIBIT
- CSR_MHPMOVF (12'h7C0)
REQ-016 csr_rdata_o and csr_hit_o SHALL be combinational on csr_addr_i (zero read latency); unowned addresses read 0.
REQ-017 A write SHALL take effect at the next rising edge; writes to unowned addresses SHALL be ignored.
REQ-018 Counter k SHALL increment by exactly 1 in a cycle when all of the following hold; multiple matching events still add only 1:
- (event_i & mhpmevent_k) is nonzero
- inhibit[k] is 0
- count_stop_i is 0
REQ-019 MHPMCOUNTERk low-half read SHALL return counter[31:0], zero-extended when CounterWidth<32.
REQ-020 MHPMCOUNTERkH read SHALL return counter[CounterWidth-1:32], zero-extended, or 0 when CounterWidth<=32.
REQ-021 A low-half or high-half write SHALL replace only the bits of that half, truncated to CounterWidth.
REQ-022 When a CSR write and an increment of the same counter coincide, the write SHALL win and the increment SHALL be dropped.
REQ-023 Overflow: an increment from all-ones SHALL wrap the counter to 0 and set ovf[k] on the same edge.
REQ-024 MHPMEVENTk SHALL store wdata[NumEvents-1:0]; reads SHALL be zero-extended.
REQ-025 MCOUNTINHIBIT:
- bits [3+NumCounters-1:3] are read/write
- all other bits read 0, including bits 2:0, which are owned by the core CSR file
REQ-026 CSR_MHPMOVF:
- reads return ovf at bit positions 3+k
- writes are write-1-to-clear
- if a set and a clear of the same bit coincide, the set SHALL win
REQ-027 ovf_irq_o SHALL be the registered-state OR of all ovf bits, with no extra cycle delay.
REQ-028 Unimplemented counters (index >= 3+NumCounters):
- their event, counter, inhibit and ovf bits SHALL read 0
- writes to them SHALL be ignored
- csr_hit_o SHALL still be 1 for their addresses
REQ-029 With NumCounters=0, the block SHALL contain no flops and every owned address SHALL read 0.

Reset
REQ-030 Asserting rst_ni, including mid-count, SHALL immediately set:
- all counters to 0
- all mhpmevent masks to 0
- all ovf bits to 0
- ovf_irq_o to 0
- all implemented inhibit bits to 1
REQ-031 The first increment SHALL be possible only after software clears the corresponding inhibit bit.

Structure
REQ-032 The shared package SHALL hold:
- CSR_MHPMOVF (12'h7C0) added to csr_num_e
- HPM_MAX_COUNTERS = 29
- HPM_FIRST_IDX = 3
- HPM_MAX_WIDTH = 64
REQ-033 The per-counter register, its increment, wrap and overflow detect SHALL live in sub-module ibex_hpm_counter (parameter CounterWidth), instantiated NumCounters times in a generate loop.
REQ-034 Read muxing and address decode SHALL live in ibex_hpm_unit.

Verification
REQ-035 Reset value: after reset, read MCOUNTINHIBIT -> 0x0000_1FF8 (NumCounters=10); pulse events -> every counter reads 0.
REQ-036 Counting: clear inhibit, set MHPMEVENT3=0x3, drive event_i=0x3 for 5 cycles -> MHPMCOUNTER3 reads 5 (not 10).
REQ-037 Wrap (CounterWidth=40): write MHPMCOUNTER4H=0xFF and low=0xFFFF_FFFF, then one event ->
- counter reads 0
- MHPMOVF bit 4 is set
- ovf_irq_o=1
REQ-038 Write precedence: write MHPMCOUNTER3=0x100 in the same cycle as an enabled event -> reads 0x100.
REQ-039 W1C race: set ovf[3]; write MHPMOVF=0x8 in the same cycle as counter 3 wraps again -> bit 3 stays 1.
REQ-040 Stop and unimplemented: count_stop_i=1 with events active -> counts unchanged; write MHPMCOUNTER20 -> reads 0 and csr_hit_o=1.
